crc_packet_framer: RTL and testbench

- Upstream stage of the CRC checker. Collects payload bytes from a producer and buffers one packet. Computes CRC-8 over the packet while it fills.
- Emits the packet in the checker's order: length on the count channel, then the payload bytes, then one CRC byte, all on the data channel.
- Single clock domain. All channels use a valid/ready handshake; a transfer occurs on a rising clk edge where valid && ready.

---
 rtl/crc_packet_framer.sv | 156 +++++++++++++++
 tb/tb_crc_packet_framer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc_packet_framer.sv
// crc_packet_framer: buffers one payload packet while computing its CRC-8,
// then emits the length on the count channel followed by the payload bytes
// and the CRC byte on the data channel.
// Optional feature macro: CRC_FRAMER_ERR_INJECT_EN (adds err_inject input that
// flips the CRC LSB of the packet whose final byte was accepted with it high).
module crc_packet_framer #(
  parameter int unsigned MAX_LEN  = 16,
  parameter logic [7:0]  POLY     = 8'h07,
  parameter logic [7:0]  CRC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       count_valid,
  input  logic       count_ready,
  output logic [7:0] count_data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       overflow
`ifdef CRC_FRAMER_ERR_INJECT_EN
  ,
  input  logic       err_inject
`endif
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_COUNT,
    S_DATA,
    S_CRC
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] crc_q, crc_d;
  logic       overflow_q, overflow_d;
  logic       err_q, err_d;
  logic       wr_en;
  logic [8:0] len_inc;
  logic       at_max;
  logic [7:0] mem_q [0:(1<<AW)-1];

  // MSB-first CRC-8 update of one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  assign len_inc = {1'b0, len_q} + 9'd1;
  assign at_max  = (len_inc == 9'(MAX_LEN));

  // Next-state and output decode for the fill / count / data / crc sequence.
  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    crc_d       = crc_q;
    overflow_d  = 1'b0;
    err_d       = err_q;
    wr_en       = 1'b0;
    in_ready    = 1'b0;
    count_valid = 1'b0;
    count_data  = 8'h00;
    data_valid  = 1'b0;
    data_out    = 8'h00;
    unique case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          len_d = len_inc[7:0];
          crc_d = crc8(crc_q, in_data);
          if (in_last || at_max) begin
            state_d    = S_COUNT;
            overflow_d = !in_last;
`ifdef CRC_FRAMER_ERR_INJECT_EN
            err_d      = err_inject;
`endif
          end
        end
      end
      S_COUNT: begin
        count_valid = 1'b1;
        count_data  = len_q;
        if (count_ready) begin
          state_d  = S_DATA;
          rd_ptr_d = 8'd0;
        end
      end
      S_DATA: begin
        data_valid = 1'b1;
        data_out   = mem_q[rd_ptr_q[AW-1:0]];
        if (data_ready) begin
          rd_ptr_d = rd_ptr_q + 8'd1;
          if (rd_ptr_q == len_q - 8'd1) state_d = S_CRC;
        end
      end
      S_CRC: begin
        data_valid = 1'b1;
        data_out   = crc_q ^ {7'b0, err_q};
        if (data_ready) begin
          len_d   = 8'd0;
          crc_d   = CRC_INIT;
          err_d   = 1'b0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  assign overflow = overflow_q;

  // Control state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      len_q      <= 8'd0;
      rd_ptr_q   <= 8'd0;
      crc_q      <= CRC_INIT;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      crc_q      <= crc_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is not reset; len gates every read, so stale contents are never emitted.
    if (wr_en) mem_q[len_q[AW-1:0]] <= in_data;
  end

  // The upper pointer bits only matter for the length compare.
  logic unused_ok;
  assign unused_ok = ^{len_inc[8]};

endmodule

// File: tb/tb_crc_packet_framer.sv
// Directed bench for crc_packet_framer with hand-computed CRC values.
module tb_crc_packet_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       count_valid;
  logic       count_ready = 1'b1;
  logic [7:0] count_data;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       overflow;
`ifdef CRC_FRAMER_ERR_INJECT_EN
  logic       err_inject = 1'b0;
`endif

  crc_packet_framer #(.MAX_LEN(16), .POLY(8'h07), .CRC_INIT(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .count_data  (count_data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .overflow    (overflow)
`ifdef CRC_FRAMER_ERR_INJECT_EN
    ,
    .err_inject  (err_inject)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;

  logic [7:0] rx_len;
  logic [7:0] rx_q [$];
  logic [7:0] pkt_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC-8 (poly 07, init 00), used only where no table constant is given.
  function automatic logic [7:0] ref_crc(input logic [7:0] b [$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (b[k]) begin
      c = c ^ b[k];
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

  // Drive one payload byte; starts and ends on a falling edge.
  task automatic push(input logic [7:0] d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Receive one frame into rx_len / rx_q, optionally stalling both channels.
  task automatic collect(input int cnt_stall, input bit rnd);
    int         guard = 0;
    logic [7:0] held;
    logic [7:0] prev = 8'h00;
    bit         stalled = 1'b0;
    rx_q.delete();
    count_ready = (cnt_stall == 0);
    while (!count_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("count_wait", {31'b0, count_valid}, 32'd1);
    held = count_data;
    for (int i = 0; i < cnt_stall; i++) begin
      @(negedge clk);
      check("count_hold", {23'b0, count_valid, count_data}, {23'b0, 1'b1, held});
    end
    count_ready = 1'b1;
    rx_len = count_data;
    @(negedge clk);
    guard = 0;
    while (rx_q.size() < int'(rx_len) + 1 && guard < 600) begin
      if (data_valid) begin
        if (stalled) check("data_hold", {24'b0, data_out}, {24'b0, prev});
        data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        prev    = data_out;
        stalled = !data_ready;
        if (data_ready) rx_q.push_back(data_out);
      end
      @(negedge clk);
      guard++;
    end
    data_ready = 1'b1;
    check("drain_done", rx_q.size(), int'(rx_len) + 1);
  endtask

  // Compare the last collected frame with a payload and CRC byte.
  task automatic check_frame(input string tag, input logic [7:0] exp_crc);
    check({tag, "_len"}, {24'b0, rx_len}, pkt_q.size());
    for (int i = 0; i < pkt_q.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, {24'b0, rx_q[i]}, {24'b0, pkt_q[i]});
    if (rx_q.size() == pkt_q.size() + 1)
      check({tag, "_crc"}, {24'b0, rx_q[pkt_q.size()]}, {24'b0, exp_crc});
    else
      check({tag, "_size"}, rx_q.size(), pkt_q.size() + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",    {31'b0, in_ready},    32'd1);
    check("rst_count_valid", {31'b0, count_valid}, 32'd0);
    check("rst_count_data",  {24'b0, count_data},  32'd0);
    check("rst_data_valid",  {31'b0, data_valid},  32'd0);
    check("rst_data_out",    {24'b0, data_out},    32'd0);
    check("rst_overflow",    {31'b0, overflow},    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 01: exact timeline, in_ready low for 3 cycles.
    push(8'h01, 1'b1);
    check("t1_count_valid", {31'b0, count_valid}, 32'd1);
    check("t1_count_data",  {24'b0, count_data},  32'd1);
    check("t1_in_ready0",   {31'b0, in_ready},    32'd0);
    @(negedge clk);
    check("t1_data0",       {23'b0, data_valid, data_out}, {23'b0, 1'b1, 8'h01});
    check("t1_in_ready1",   {31'b0, in_ready},    32'd0);
    @(negedge clk);
    check("t1_crc",         {23'b0, data_valid, data_out}, {23'b0, 1'b1, 8'h07});
    check("t1_in_ready2",   {31'b0, in_ready},    32'd0);
    @(negedge clk);
    check("t1_in_ready3",   {31'b0, in_ready},    32'd1);
    check("t1_idle",        {30'b0, count_valid, data_valid}, 32'd0);

    // Two bytes 01 02 -> CRC 1B.
    pkt_q = '{8'h01, 8'h02};
    push(8'h01, 1'b0);
    push(8'h02, 1'b1);
    collect(0, 1'b0);
    check_frame("t2", 8'h1B);

    // "123456789" -> CRC F4.
    pkt_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    foreach (pkt_q[i]) push(pkt_q[i], i == 8);
    collect(0, 1'b0);
    check_frame("t3", 8'hF4);

    // 20 bytes with last on the 20th: force-close at 16, then a 4-byte packet.
    ovf_cnt = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) push(8'(8'h10 + i), i == 19);
      end
      begin
        pkt_q.delete();
        for (int i = 0; i < 16; i++) pkt_q.push_back(8'(8'h10 + i));
        collect(0, 1'b0);
        check_frame("t4a", ref_crc(pkt_q));
        pkt_q.delete();
        for (int i = 16; i < 20; i++) pkt_q.push_back(8'(8'h10 + i));
        collect(0, 1'b0);
        check_frame("t4b", ref_crc(pkt_q));
      end
    join
    check("t4_overflow_pulses", ovf_cnt, 1);

    // Stalled consumer: count held 5 cycles, random data_ready.
    pkt_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (pkt_q[i]) push(pkt_q[i], i == 3);
    collect(5, 1'b1);
    check_frame("t5", ref_crc(pkt_q));

    // Reset during DATA after 2 of 5 bytes accepted.
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), i == 4);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t6_mid_data", {23'b0, data_valid, data_out}, {23'b0, 1'b1, 8'hA2});
    rst_n = 1'b0;
    #1;
    check("t6_rst_valids", {30'b0, count_valid, data_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    pkt_q = '{8'h00};
    push(8'h00, 1'b1);
    collect(0, 1'b0);
    check_frame("t6", 8'h00);

    check("total_overflow_pulses", ovf_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
